// File: rtl/mem_access_unit_if.sv
`default_nettype none
// ============================================================================
// mem_access_unit_if : data-memory bus between the MEM stage and memory
// Rev 1.0
// ============================================================================
interface mem_access_unit_if #(
  parameter int WIDTH = 16
);
  logic             dmem_read;
  logic             dmem_write;
  logic [WIDTH-1:0] dmem_address;
  logic [WIDTH-1:0] dmem_wdata;
  logic [1:0]       dmem_byte_enable;
  logic [WIDTH-1:0] dmem_rdata;
  logic             dmem_resp;

  modport master (
    output dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable,
    input  dmem_rdata, dmem_resp
  );

  modport slave (
    input  dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable,
    output dmem_rdata, dmem_resp
  );
endinterface
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// mem_access_unit : LC-3b MEM-stage sequencer for LDR/LDB/LDI/STR/STB/STI
// Rev 1.0
// ============================================================================
module mem_access_unit #(
  parameter int WIDTH = 16
) (
  input  wire logic             clk,
  input  wire logic             reset_n,
  input  wire logic             mem_valid_in,
  input  wire logic [3:0]       mem_opcode_in,
  input  wire logic [WIDTH-1:0] mem_addr_in,
  input  wire logic [WIDTH-1:0] mem_store_data_in,
  output logic      [WIDTH-1:0] mem_data_out,
  output logic                  mem_done,
  output logic                  stall,
  mem_access_unit_if.master     dmem
);

  localparam logic [3:0] c_OP_LDB = 4'b0010;
  localparam logic [3:0] c_OP_STB = 4'b0011;
  localparam logic [3:0] c_OP_LDR = 4'b0110;
  localparam logic [3:0] c_OP_STR = 4'b0111;
  localparam logic [3:0] c_OP_LDI = 4'b1010;
  localparam logic [3:0] c_OP_STI = 4'b1011;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS1 = 2'd1,
    S_ACCESS2 = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t           r_state;
  logic [3:0]       r_op;
  logic             r_byte_sel;
  logic             r_read;
  logic             r_write;
  logic [WIDTH-1:0] r_address;
  logic [WIDTH-1:0] r_wdata;
  logic [1:0]       r_be;
  logic [WIDTH-1:0] r_data_out;
  logic             r_done;

  logic             w_is_mem;
  logic             w_accept;
  logic             w_is_byte;
  logic             w_is_store_first;
  logic [WIDTH-1:0] w_addr_next;
  logic [WIDTH-1:0] w_wdata_next;
  logic [1:0]       w_be_next;
  logic             w_indirect;
  logic [7:0]       w_ld_byte;

  always_comb begin
    w_is_mem = (mem_opcode_in == c_OP_LDB) || (mem_opcode_in == c_OP_STB) ||
               (mem_opcode_in == c_OP_LDR) || (mem_opcode_in == c_OP_STR) ||
               (mem_opcode_in == c_OP_LDI) || (mem_opcode_in == c_OP_STI);
    w_is_byte        = (mem_opcode_in == c_OP_LDB) || (mem_opcode_in == c_OP_STB);
    w_is_store_first = (mem_opcode_in == c_OP_STR) || (mem_opcode_in == c_OP_STB);
    w_accept         = (r_state == S_IDLE) && mem_valid_in && w_is_mem;
    // Byte ops present the exact byte address; word ops drop bit 0.
    w_addr_next  = w_is_byte ? mem_addr_in : {mem_addr_in[WIDTH-1:1], 1'b0};
    w_wdata_next = (mem_opcode_in == c_OP_STB) ?
                   {mem_store_data_in[7:0], mem_store_data_in[7:0]} : mem_store_data_in;
    w_be_next    = 2'b11;
    if (mem_opcode_in == c_OP_STB) begin
      w_be_next = mem_addr_in[0] ? 2'b10 : 2'b01;
    end
    w_indirect = (r_op == c_OP_LDI) || (r_op == c_OP_STI);
    w_ld_byte  = r_byte_sel ? dmem.dmem_rdata[15:8] : dmem.dmem_rdata[7:0];
  end

  // The acceptance cycle stalls combinationally so the instruction holds in MEM.
  assign stall = reset_n &&
                 (w_accept || (r_state == S_ACCESS1) || (r_state == S_ACCESS2));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_op       <= 4'd0;
      r_byte_sel <= 1'b0;
      r_read     <= 1'b0;
      r_write    <= 1'b0;
      r_address  <= '0;
      r_wdata    <= '0;
      r_be       <= 2'b00;
      r_data_out <= '0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (w_accept) begin
            r_state    <= S_ACCESS1;
            r_op       <= mem_opcode_in;
            r_byte_sel <= mem_addr_in[0];
            r_address  <= w_addr_next;
            r_wdata    <= w_wdata_next;
            r_be       <= w_be_next;
            r_read     <= !w_is_store_first;
            r_write    <= w_is_store_first;
          end
        end
        S_ACCESS1: begin
          if (dmem.dmem_resp) begin
            if (w_indirect) begin
              // Read data is the pointer for the second access.
              r_state   <= S_ACCESS2;
              r_address <= {dmem.dmem_rdata[WIDTH-1:1], 1'b0};
              r_be      <= 2'b11;
              r_read    <= (r_op == c_OP_LDI);
              r_write   <= (r_op == c_OP_STI);
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_read  <= 1'b0;
              r_write <= 1'b0;
              if (r_op == c_OP_LDR) begin
                r_data_out <= dmem.dmem_rdata;
              end else if (r_op == c_OP_LDB) begin
                r_data_out <= {{(WIDTH-8){1'b0}}, w_ld_byte};
              end
            end
          end
        end
        S_ACCESS2: begin
          if (dmem.dmem_resp) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_read  <= 1'b0;
            r_write <= 1'b0;
            if (r_op == c_OP_LDI) begin
              r_data_out <= dmem.dmem_rdata;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_read  <= 1'b0;
          r_write <= 1'b0;
        end
      endcase
    end
  end

  assign dmem.dmem_read        = r_read;
  assign dmem.dmem_write       = r_write;
  assign dmem.dmem_address     = r_address;
  assign dmem.dmem_wdata       = r_wdata;
  assign dmem.dmem_byte_enable = r_be;
  assign mem_data_out          = r_data_out;
  assign mem_done              = r_done;

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter: WIDTH, 16, data/address word width; the only supported value is 16.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 mem_valid_in  input  1  MEM-stage instruction valid.
REQ-005 mem_opcode_in  input  4  lc3b_opcode of the MEM-stage instruction.
REQ-006 mem_addr_in  input  16  effective address, equal to the EX-stage ALU result.
REQ-007 mem_store_data_in  input  16  store source register value.
REQ-008 dmem_read  output  1  data-memory read request.
REQ-009 dmem_write  output  1  data-memory write request.
REQ-010 dmem_address  output  16  data-memory address.
REQ-011 dmem_wdata  output  16  data-memory write data.
REQ-012 dmem_byte_enable  output  2  write byte lanes; bit 1 is the high byte.
REQ-013 dmem_rdata  input  16  data-memory read data, valid when dmem_resp=1.
REQ-014 dmem_resp  input  1  single-cycle data-memory completion.
REQ-015 mem_data_out  output  16  load result, held until the next load completes.
REQ-016 mem_done  output  1  one-cycle pulse marking memory-instruction completion.
REQ-017 stall  output  1  holds the upstream pipeline while an access is outstanding.

Function
REQ-018 Memory opcodes are LDR, LDB, LDI, STR, STB and STI; all other opcodes are non-memory.
REQ-019 States are IDLE, ACCESS1, ACCESS2 and DONE.
REQ-020 In IDLE with mem_valid_in=1 and a memory opcode:
- Latch the opcode, address and store data.
- Drive stall=1 combinationally in the same cycle.
- Go to ACCESS1 on the next edge.
REQ-021 In IDLE with a non-memory opcode or mem_valid_in=0: stall=0, mem_done=0, remain in IDLE.
REQ-022 ACCESS1 request, driven from latched values:
- LDR, LDB, LDI, STI: dmem_read=1.
- STR, STB: dmem_write=1.
- Address is the latched mem_addr_in.
REQ-023 ACCESS2 request, for LDI/STI only:
- Address is the pointer captured from the ACCESS1 read data.
- LDI drives dmem_read=1; STI drives dmem_write=1.
REQ-024 Requests, address, wdata and byte_enable hold stable until dmem_resp=1; waits are unbounded.
REQ-025 On dmem_resp in ACCESS1:
- LDI/STI capture dmem_rdata as the pointer and go to ACCESS2.
- All other memory opcodes go to DONE.
REQ-026 On dmem_resp in ACCESS2, go to DONE.
REQ-027 stall=1 in ACCESS1 and ACCESS2, including the response cycle.
REQ-028 DONE drives mem_done=1 and stall=0, then returns to IDLE unconditionally; a new request is accepted in the following cycle.
REQ-029 Word accesses drive dmem_address={addr[15:1],1'b0} and byte_enable=2'b11; misalignment is silently truncated.
REQ-030 STB drives dmem_address=addr, wdata={data[7:0],data[7:0]}, and byte_enable=2'b10 if addr[0]=1, else 2'b01.
REQ-031 LDB result is the byte selected by addr[0] (1 selects the high byte), zero-extended to 16 bits.
REQ-032 LDR result is dmem_rdata; LDI result is the ACCESS2 dmem_rdata.
REQ-033 mem_data_out is registered on the final load response.
REQ-034 dmem_read and dmem_write are never both 1; both are 0 in IDLE and DONE.
REQ-035 dmem_resp is ignored in IDLE and DONE.
REQ-036 Store completions pulse mem_done and leave mem_data_out unchanged.

Reset
REQ-037 While reset_n=0, asynchronously force:
- State IDLE.
- dmem_read=0, dmem_write=0, dmem_byte_enable=0, dmem_address=0, dmem_wdata=0.
- mem_data_out=0, mem_done=0, stall=0.
- All latched registers=0.
REQ-038 A reset during ACCESS1/ACCESS2 abandons the access; a dmem_resp arriving after reset deassertion is ignored.

Verification
REQ-039 LDR, addr=0x1235, rdata=0xBEEF, resp after 3 waits -> dmem_address=0x1234, read held 4 cycles, mem_data_out=0xBEEF, one mem_done pulse.
REQ-040 STB, addr=0x2001, data=0x00A5 -> wdata=0xA5A5, byte_enable=2'b10, write=1 until resp, mem_data_out unchanged.
REQ-041 LDB, addr=0x3000, rdata=0x7F80 -> mem_data_out=0x0080.
REQ-042 LDI, addr=0x4000: ACCESS1 rdata=0x5002; ACCESS2 rdata=0x1111 -> second read at 0x5002, mem_data_out=0x1111, stall high until DONE.
REQ-043 STI, addr=0x4000, pointer=0x6000, data=0xCAFE -> read at 0x4000, then write at 0x6000 with 0xCAFE and byte_enable=2'b11.
REQ-044 Reset asserted mid-ACCESS1 of STR -> all outputs 0 immediately; a later resp produces no mem_done; ADD in IDLE -> stall=0.
